regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) among NREQ writeback requesters, such as ALU and load writeback, using round-robin arbitration and a valid/ready handshake. After every reset it first runs an init sweep that writes zero to registers 1..DEPTH-1. It sits between the writeback sources and the register file, driving the write port directly.

Parameters:
DEPTH, 32, number of registers; address width AW = $clog2(DEPTH)
WIDTH, 32, data width in bits
NREQ, 2, number of write requesters (>=2)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
req_valid  input  NREQ  bit i: requester i presents a write
req_addr  input  NREQ*AW  requester i destination address at [i*AW +: AW]
req_data  input  NREQ*WIDTH  requester i write data at [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot or zero; bit i: requester i's write is accepted this cycle
WE3  output  1  register-file write enable
A3  output  AW  register-file write address
WD3  output  WIDTH  register-file write data
init_done  output  1  1 once the init sweep is complete

Behaviour:
- State: FSM {INIT, RUN}, sweep counter cnt (AW bits), round-robin pointer ptr ($clog2(NREQ) bits), init_done register.
- RST sampled high at an edge: state=INIT, cnt=1, ptr=0, init_done=0. RST has priority over every other event.
- INIT outputs (combinational from state): WE3=1, A3=cnt, WD3=0, req_ready=0.
  - Each cycle, cnt increments.
  - In the cycle with cnt==DEPTH-1, the next state is RUN and init_done becomes 1 at that edge.
  - The sweep takes exactly DEPTH-1 cycles (addresses 1..DEPTH-1).
  - Register 0 is never written, because reads of address 0 return 0.
- RUN arbitration (combinational, zero latency):
  - Scan indices ptr, ptr+1, ... mod NREQ; the first i with req_valid[i]=1 is the grant g.
  - req_ready[g]=1; all other ready bits are 0.
  - A3=req_addr[g] and WD3=req_data[g]; WE3=1 unless req_addr[g]==0.
  - The register file captures the write at the same edge the handshake completes.
- A write to address 0 is still accepted (ready=1) and counts as a grant, but WE3=0 so the write is dropped.
- No valid in RUN: req_ready=0, WE3=0, A3=0, WD3=0; ptr unchanged.
- On a grant, ptr <= (g+1) mod NREQ. With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- Handshake rules:
  - A transfer completes in a cycle where valid and ready are both 1.
  - A requester holds valid, addr and data stable until ready.
  - req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
- Any requester starvation is bounded: it waits at most NREQ-1 grants.
- Reset mid-operation: RST during RUN or INIT restarts the INIT sweep from cnt=1.
  - A request pending in the reset cycle is not acknowledged.
  - Register contents are re-zeroed.
- Requests presented during INIT are held off (ready=0) and are not lost, provided the requester keeps valid asserted.
- init_done stays 1 until the next reset.

Test Plan:
1. DEPTH=32: assert RST 1 cycle then release -> WE3=1, WD3=0, A3 = 1,2,...,31 on 31 consecutive cycles; init_done=1 on the next cycle; register-file readback of all 32 addresses = 0.
2. After init, req_valid=01, req_addr[0]=5, req_data[0]=32'hDEADBEEF -> same cycle req_ready=01, WE3=1, A3=5; RD1 at A1=5 = 32'hDEADBEEF afterwards.
3. Both valid continuously for 4 cycles, req0 addr 3/data 32'h11, req1 addr 4/data 32'h22 -> req_ready sequence 01,10,01,10 (ptr starts at 0) -> reg3=32'h11, reg4=32'h22.
4. req_valid=10, req_addr[1]=0, data 32'hFFFFFFFF -> req_ready=10, WE3=0, ptr advances to 0; reading address 0 still returns 0.
5. req0 valid during INIT (cycle 10 of the sweep) -> ready=0 until init_done=1; accepted on the first RUN cycle with WE3=1.
6. RST pulsed for 1 cycle while both requesters are valid in RUN -> no ready in the reset cycle, a full 31-cycle sweep follows, previously written reg3 reads 0, then arbitration restarts at req0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback requesters and the register-file write arbiter,
// carrying the request handshake, the register-file write port and status.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: requester i transfers in a cycle where req_valid[i] and req_ready[i]
    // are both 1. A requester holds valid/addr/data stable until ready. req_ready
    // may depend combinationally on req_valid, but req_valid never depends on req_ready.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    logic                  WE3;
    logic [AW-1:0]         A3;
    logic [WIDTH-1:0]      WD3;
    logic                  init_done;
    logic                  state;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, WE3, A3, WD3, init_done, state
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, WE3, A3, WD3, init_done, state
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// sources; after every reset it first sweeps zeros into registers 1..DEPTH-1.
module regfile_write_arbiter #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    regfile_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic [PW-1:0]    ptr;
    logic             init_done_q;

    logic             found;
    logic [PW-1:0]    grant;
    logic [AW-1:0]    grant_addr;
    logic [WIDTH-1:0] grant_data;

    // First valid requester scanning from ptr upward, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = PW'(idx);
            end
        end
    end

    assign grant_addr = bus.req_addr[int'(grant)*AW +: AW];
    assign grant_data = bus.req_data[int'(grant)*WIDTH +: WIDTH];

    // Outputs are held quiet in a reset cycle so a pending request is not acknowledged.
    always_comb begin
        bus.req_ready = '0;
        bus.WE3       = 1'b0;
        bus.A3        = '0;
        bus.WD3       = '0;
        if (!RST) begin
            if (state == S_INIT) begin
                bus.WE3 = 1'b1;
                bus.A3  = cnt;
            end else if (found) begin
                bus.req_ready[grant] = 1'b1;
                bus.A3               = grant_addr;
                bus.WD3              = grant_data;
                bus.WE3              = (grant_addr != '0);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_INIT;
            cnt         <= AW'(1);
            ptr         <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state       <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (found) begin
                        ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.state     = state;
endmodule
